minmax_reduce_pipe: RTL and testbench
=====================================

// Module: minmax_reduce_pipe
// PURPOSE
//  Pipelined, parametrised min/max reducer for the haze-removal datapath.
//  Each accepted beat carries LANES unsigned pixel values. Each beat yields its extremum and the winning lane index.
//  Beats are also reduced over a frame (in_last ends the frame), e.g. atmospheric-light max over the dark channel.
//  Supersedes the fixed 5-input max finder: adds width/lane params, min/max mode, handshakes, frame accumulation.
// PARAMETERS
//  WIDTH  10  bits per lane value (unsigned)
//  LANES  5   values per beat; legal range 2..16
//  CNTW   16  width of frame beat counter/index
//  (local) IDXW = $clog2(LANES); STAGES = $clog2(LANES)
// PORTS
//  clock        in   1            rising-edge clock
//  reset_n      in   1            synchronous reset, active-low
//  mode         in   1            0=min, 1=max; sampled with each accepted beat
//  in_valid     in   1            beat valid
//  in_ready     out  1            beat accepted when in_valid && in_ready
//  in_data      in   LANES*WIDTH  lane k at [k*WIDTH +: WIDTH]
//  in_last      in   1            final beat of frame
//  out_valid    out  1            per-beat result valid
//  out_ready    in   1            downstream accepts when out_valid && out_ready
//  out_value    out  WIDTH        beat extremum
//  out_index    out  IDXW         winning lane
//  out_last     out  1            in_last carried through
//  frame_done   out  1            1-cycle pulse: frame result updated
//  frame_value  out  WIDTH        frame extremum (held until next frame_done)
//  frame_beat   out  CNTW         beat number (0-based) of frame winner
//  frame_lane   out  IDXW         lane of frame winner
//  frame_count  out  CNTW         beats in completed frame (saturating)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): all valid bits, outputs, accumulator, counters -> 0. in_ready=1 after reset.
//    Reset mid-frame discards the partial frame; no frame_done.
//  - Tree: STAGES registered compare levels; odd operand passes through with its index. mode travels with data.
//  - Compare: max mode picks b only if b>a; min mode picks b only if b<a; a = lower lane.
//    Ties resolve to the lowest lane index.
//  - Latency: STAGES cycles from acceptance to out_valid, no stall (LANES=5 -> 3). Throughput 1 beat/cycle.
//  - Stall: stall = out_valid && !out_ready. The whole pipe freezes on stall; in_ready = !stall (combinational).
//    Bubbles are not compressed. out_* stable while stalled. No beat dropped or duplicated; order preserved.
//  - Frame accumulator updates on each output handshake:
//    - First beat of frame: load value/lane, beat=0, latch frame mode from that beat.
//    - Later beats: replace only if strictly better under latched frame mode.
//      Ties keep the earliest beat. Mode changes mid-frame do not alter frame compare.
//    - beat counter increments per handshake, saturating at 2^CNTW-1.
//  - Handshake with out_last: frame_value/beat/lane/count take the final result one cycle later, frame_done=1.
//    Accumulator re-arms for the next frame; the following beat starts a new frame.
//    A single-beat frame (in_last on first beat) is legal.
//  - frame_* outputs change only with frame_done; frame_done never asserts twice for one frame.
// TESTING (LANES=5, WIDTH=10, out_ready=1 unless stated)
//  1 max, {12,700,45,700,3}, last=1 -> out_value=700, out_index=1, out_valid 3 cycles after accept;
//    next cycle frame_done, frame_value=700, frame_beat=0, frame_lane=1, frame_count=1.
//  2 min, {9,4,4,1023,200} -> out_value=4, out_index=1; {0,0,0,0,0} -> value 0, index 0.
//  3 6 beats back-to-back, out_ready=0 for 5 cycles mid-stream -> in_ready=0 while stalled;
//    all 6 results emerge in order, none lost or duplicated.
//  4 max frame, beat maxima 300,900,900 (last on 3rd) -> frame_value=900, frame_beat=1, frame_count=3.
//  5 reset_n=0 one cycle after beat 1 of a 3-beat frame -> all outputs 0, no frame_done;
//    a fresh 1-beat frame then reports frame_count=1.
//  6 two frames back-to-back: max {1,2,3,4,5}+last, then min {5,4,3,2,1}+last ->
//    two frame_done pulses, frame_value 5 then 1, frame_lane 4 both.

Source files
------------

// File: rtl/minmax_reduce_pipe.sv
// minmax_reduce_pipe
//   Pipelined min/max reducer. Each accepted beat carries LANES unsigned
//   values. A binary compare tree of STAGES registered levels produces the
//   beat extremum and its lane. A frame accumulator then folds the per-beat
//   results over a frame that ends with in_last.
//
// Ports
//   clock        rising-edge clock
//   reset_n      synchronous reset, active-low
//   mode         0 = min, 1 = max; travels with the beat
//   in_valid     beat valid
//   in_ready     beat accepted when in_valid && in_ready
//   in_data      lane k at [k*WIDTH +: WIDTH]
//   in_last      final beat of the frame
//   out_valid    per-beat result valid
//   out_ready    downstream accepts when out_valid && out_ready
//   out_value    beat extremum
//   out_index    winning lane
//   out_last     in_last carried through
//   frame_done   one-cycle pulse: frame_* updated
//   frame_value  frame extremum
//   frame_beat   0-based beat number of the frame winner
//   frame_lane   lane of the frame winner
//   frame_count  beats in the completed frame (saturating)
module minmax_reduce_pipe #(
  parameter  int WIDTH  = 10,
  parameter  int LANES  = 5,
  parameter  int CNTW   = 16,
  localparam int IDXW   = $clog2(LANES),
  localparam int STAGES = $clog2(LANES)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_value,
  output logic [IDXW-1:0]        out_index,
  output logic                   out_last,
  output logic                   frame_done,
  output logic [WIDTH-1:0]       frame_value,
  output logic [CNTW-1:0]        frame_beat,
  output logic [IDXW-1:0]        frame_lane,
  output logic [CNTW-1:0]        frame_count
);

  // Number of operands entering compare level l.
  function automatic int level_count(input int l);
    return (LANES + (1 << l) - 1) >> l;
  endfunction

  // Registered outputs of each compare level.
  logic [WIDTH-1:0] st_val_reg [STAGES][LANES];
  logic [IDXW-1:0]  st_idx_reg [STAGES][LANES];
  logic             st_vld_reg  [STAGES];
  logic             st_mode_reg [STAGES];
  logic             st_last_reg [STAGES];

  // Operands entering each level and the level's combinational result.
  logic [WIDTH-1:0] src_val [STAGES][LANES];
  logic [IDXW-1:0]  src_idx [STAGES][LANES];
  logic             src_vld  [STAGES];
  logic             src_mode [STAGES];
  logic             src_last [STAGES];
  logic [WIDTH-1:0] nxt_val [STAGES][LANES];
  logic [IDXW-1:0]  nxt_idx [STAGES][LANES];

  logic stall;

  assign out_valid = st_vld_reg[STAGES-1];
  assign out_value = st_val_reg[STAGES-1][0];
  assign out_index = st_idx_reg[STAGES-1][0];
  assign out_last  = st_last_reg[STAGES-1];

  // The whole pipe freezes while the result is held; bubbles are kept.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    for (int l = 0; l < STAGES; l++) begin
      src_vld[l]  = 1'b0;
      src_mode[l] = 1'b0;
      src_last[l] = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        src_val[l][k] = '0;
        src_idx[l][k] = '0;
        nxt_val[l][k] = '0;
        nxt_idx[l][k] = '0;
      end
    end

    src_vld[0]  = in_valid;
    src_mode[0] = mode;
    src_last[0] = in_last;
    for (int k = 0; k < LANES; k++) begin
      src_val[0][k] = in_data[k*WIDTH +: WIDTH];
      src_idx[0][k] = IDXW'(k);
    end
    for (int l = 1; l < STAGES; l++) begin
      src_vld[l]  = st_vld_reg[l-1];
      src_mode[l] = st_mode_reg[l-1];
      src_last[l] = st_last_reg[l-1];
      for (int k = 0; k < LANES; k++) begin
        src_val[l][k] = st_val_reg[l-1][k];
        src_idx[l][k] = st_idx_reg[l-1][k];
      end
    end

    // Pair (2j, 2j+1); operand a is always the lower lane, so taking b only
    // on a strict win resolves ties to the lowest lane. An unpaired last
    // operand passes through unchanged.
    for (int l = 0; l < STAGES; l++) begin
      for (int j = 0; j < LANES; j++) begin
        if (2*j + 1 < level_count(l)) begin
          if (src_mode[l] ? (src_val[l][2*j+1] > src_val[l][2*j])
                          : (src_val[l][2*j+1] < src_val[l][2*j])) begin
            nxt_val[l][j] = src_val[l][2*j+1];
            nxt_idx[l][j] = src_idx[l][2*j+1];
          end else begin
            nxt_val[l][j] = src_val[l][2*j];
            nxt_idx[l][j] = src_idx[l][2*j];
          end
        end else if (2*j < level_count(l)) begin
          nxt_val[l][j] = src_val[l][2*j];
          nxt_idx[l][j] = src_idx[l][2*j];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int l = 0; l < STAGES; l++) begin
        st_vld_reg[l]  <= 1'b0;
        st_mode_reg[l] <= 1'b0;
        st_last_reg[l] <= 1'b0;
        for (int k = 0; k < LANES; k++) begin
          st_val_reg[l][k] <= '0;
          st_idx_reg[l][k] <= '0;
        end
      end
    end else if (!stall) begin
      for (int l = 0; l < STAGES; l++) begin
        st_vld_reg[l]  <= src_vld[l];
        st_mode_reg[l] <= src_mode[l];
        st_last_reg[l] <= src_last[l];
        for (int k = 0; k < LANES; k++) begin
          st_val_reg[l][k] <= nxt_val[l][k];
          st_idx_reg[l][k] <= nxt_idx[l][k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame accumulator
  // ---------------------------------------------------------------------
  logic             first_reg;      // next handshake starts a new frame
  logic             acc_mode_reg;   // mode latched from the frame's first beat
  logic [WIDTH-1:0] acc_val_reg;
  logic [IDXW-1:0]  acc_lane_reg;
  logic [CNTW-1:0]  acc_beat_reg;
  logic [CNTW-1:0]  beat_cnt_reg;   // beats handshaken so far in this frame
  logic             frame_done_reg;
  logic [WIDTH-1:0] frame_value_reg;
  logic [CNTW-1:0]  frame_beat_reg;
  logic [IDXW-1:0]  frame_lane_reg;
  logic [CNTW-1:0]  frame_count_reg;

  logic             out_hs;
  logic             better;
  logic             acc_mode_next;
  logic [WIDTH-1:0] acc_val_next;
  logic [IDXW-1:0]  acc_lane_next;
  logic [CNTW-1:0]  acc_beat_next;
  logic [CNTW-1:0]  beat_cnt_next;

  always_comb begin
    out_hs = out_valid && out_ready;
    better = acc_mode_reg ? (out_value > acc_val_reg) : (out_value < acc_val_reg);
    if (first_reg) begin
      acc_mode_next = st_mode_reg[STAGES-1];
      acc_val_next  = out_value;
      acc_lane_next = out_index;
      acc_beat_next = '0;
      beat_cnt_next = CNTW'(1);
    end else begin
      acc_mode_next = acc_mode_reg;
      acc_val_next  = better ? out_value    : acc_val_reg;
      acc_lane_next = better ? out_index    : acc_lane_reg;
      acc_beat_next = better ? beat_cnt_reg : acc_beat_reg;
      beat_cnt_next = (&beat_cnt_reg) ? beat_cnt_reg : beat_cnt_reg + CNTW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      first_reg       <= 1'b1;
      acc_mode_reg    <= 1'b0;
      acc_val_reg     <= '0;
      acc_lane_reg    <= '0;
      acc_beat_reg    <= '0;
      beat_cnt_reg    <= '0;
      frame_done_reg  <= 1'b0;
      frame_value_reg <= '0;
      frame_beat_reg  <= '0;
      frame_lane_reg  <= '0;
      frame_count_reg <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      if (out_hs) begin
        acc_mode_reg <= acc_mode_next;
        acc_val_reg  <= acc_val_next;
        acc_lane_reg <= acc_lane_next;
        acc_beat_reg <= acc_beat_next;
        beat_cnt_reg <= beat_cnt_next;
        first_reg    <= out_last;
        if (out_last) begin
          frame_done_reg  <= 1'b1;
          frame_value_reg <= acc_val_next;
          frame_beat_reg  <= acc_beat_next;
          frame_lane_reg  <= acc_lane_next;
          frame_count_reg <= beat_cnt_next;
        end
      end
    end
  end

  assign frame_done  = frame_done_reg;
  assign frame_value = frame_value_reg;
  assign frame_beat  = frame_beat_reg;
  assign frame_lane  = frame_lane_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_minmax_reduce_pipe.sv
module tb_minmax_reduce_pipe;
  localparam int WIDTH = 10;
  localparam int LANES = 5;
  localparam int CNTW  = 16;
  localparam int IDXW  = 3;
  localparam int NV    = 10;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic                   mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_value;
  logic [IDXW-1:0]        out_index;
  logic                   out_last;
  logic                   frame_done;
  logic [WIDTH-1:0]       frame_value;
  logic [CNTW-1:0]        frame_beat;
  logic [IDXW-1:0]        frame_lane;
  logic [CNTW-1:0]        frame_count;

  always #5 clock = ~clock;

  minmax_reduce_pipe #(.WIDTH(WIDTH), .LANES(LANES), .CNTW(CNTW)) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_index(out_index), .out_last(out_last),
    .frame_done(frame_done), .frame_value(frame_value), .frame_beat(frame_beat),
    .frame_lane(frame_lane), .frame_count(frame_count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] v;
    logic [IDXW-1:0]  i;
    logic             l;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] v;
    logic [CNTW-1:0]  b;
    logic [IDXW-1:0]  ln;
    logic [CNTW-1:0]  c;
  } frm_t;

  typedef struct {
    logic                   m;
    logic [LANES*WIDTH-1:0] d;
    logic [WIDTH-1:0]       ev;
    logic [IDXW-1:0]        ei;
  } vec_t;

  res_t got_q[$];
  frm_t frm_q[$];
  vec_t vt[NV];

  // Output handshakes and frame pulses, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) got_q.push_back('{out_value, out_index, out_last});
    if (frame_done) frm_q.push_back('{frame_value, frame_beat, frame_lane, frame_count});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LANES*WIDTH-1:0] pk(input int a, input int b, input int c,
                                                input int d, input int e);
    return {10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic m, input logic [LANES*WIDTH-1:0] d, input logic l);
    int n;
    bit ok;
    mode = m; in_data = d; in_last = l; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_frame(input string name, input int idx, input frm_t e);
    if (idx < frm_q.size()) begin
      chk({name, "_fval"},  32'(frm_q[idx].v),  32'(e.v));
      chk({name, "_fbeat"}, 32'(frm_q[idx].b),  32'(e.b));
      chk({name, "_flane"}, 32'(frm_q[idx].ln), 32'(e.ln));
      chk({name, "_fcnt"},  32'(frm_q[idx].c),  32'(e.c));
    end else begin
      total++; bad++;
      $display("FAIL %s_fmissing: got %0d frames expected > %0d", name, frm_q.size(), idx);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] hold_v;
    int base;

    vt[0] = '{1'b1, pk(12, 700, 45, 700, 3),          10'd700,  3'd1};
    vt[1] = '{1'b0, pk(9, 4, 4, 1023, 200),           10'd4,    3'd1};
    vt[2] = '{1'b0, pk(0, 0, 0, 0, 0),                10'd0,    3'd0};
    vt[3] = '{1'b1, pk(0, 0, 0, 0, 0),                10'd0,    3'd0};
    vt[4] = '{1'b1, pk(1, 2, 3, 4, 1023),             10'd1023, 3'd4};
    vt[5] = '{1'b0, pk(5, 4, 3, 2, 1),                10'd1,    3'd4};
    vt[6] = '{1'b1, pk(1023, 1023, 1023, 1023, 1023), 10'd1023, 3'd0};
    vt[7] = '{1'b0, pk(7, 3, 9, 3, 3),                10'd3,    3'd1};
    vt[8] = '{1'b1, pk(0, 0, 0, 0, 1),                10'd1,    3'd4};
    vt[9] = '{1'b0, pk(1, 0, 1, 0, 0),                10'd0,    3'd1};

    reset_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_value", 32'(out_value), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_value", 32'(frame_value), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    $display("reset check done");
    @(posedge clock); #1;

    // Test 1: latency and single-beat frame.
    got_q.delete(); frm_q.delete();
    send(1'b1, vt[0].d, 1'b1);
    idle();
    @(negedge clock); chk("t1_valid_c1", 32'(out_valid), 0);
    @(negedge clock); chk("t1_valid_c2", 32'(out_valid), 0);
    @(negedge clock);
    chk("t1_valid_c3", 32'(out_valid), 1);
    chk("t1_value", 32'(out_value), 700);
    chk("t1_index", 32'(out_index), 1);
    chk("t1_last", 32'(out_last), 1);
    chk("t1_fdone_early", 32'(frame_done), 0);
    @(negedge clock);
    chk("t1_fdone", 32'(frame_done), 1);
    chk("t1_fvalue", 32'(frame_value), 700);
    chk("t1_fbeat", 32'(frame_beat), 0);
    chk("t1_flane", 32'(frame_lane), 1);
    chk("t1_fcount", 32'(frame_count), 1);
    @(negedge clock);
    chk("t1_fdone_pulse", 32'(frame_done), 0);
    $display("test1 latency: value=%0d index=%0d", frame_value, frame_lane);
    @(posedge clock); #1;

    // Table: back-to-back single-beat frames.
    got_q.delete(); frm_q.delete();
    for (int i = 0; i < NV; i++) send(vt[i].m, vt[i].d, 1'b1);
    idle();
    cycles(8);
    chk("tbl_count", 32'(got_q.size()), NV);
    chk("tbl_fcount", 32'(frm_q.size()), NV);
    for (int i = 0; i < NV; i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("tbl%0d_value", i), 32'(got_q[i].v), 32'(vt[i].ev));
        chk($sformatf("tbl%0d_index", i), 32'(got_q[i].i), 32'(vt[i].ei));
        chk($sformatf("tbl%0d_last", i),  32'(got_q[i].l), 1);
        $display("vector %0d: mode=%0d value=%0d index=%0d", i, vt[i].m, got_q[i].v, got_q[i].i);
      end
      chk_frame($sformatf("tbl%0d", i), i, '{vt[i].ev, 16'd0, vt[i].ei, 16'd1});
    end

    // Test 3: six beats with a 5-cycle downstream stall.
    got_q.delete(); frm_q.delete();
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          logic [LANES*WIDTH-1:0] d;
          d = pk(1, 1, 1, 1, 1);
          d[(k % LANES)*WIDTH +: WIDTH] = 10'(10 * (k + 1));
          send(1'b1, d, k == 5);
        end
        idle();
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clock);
          n++;
        end while (!out_valid && n < 50);
        @(posedge clock); #1;
        out_ready = 1'b0;
        hold_v = out_value;
        for (int s = 0; s < 5; s++) begin
          @(negedge clock);
          chk("t3_in_ready_stall", 32'(in_ready), 0);
          chk("t3_valid_stall", 32'(out_valid), 1);
          chk("t3_value_hold", 32'(out_value), 32'(hold_v));
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    cycles(10);
    chk("t3_count", 32'(got_q.size()), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < got_q.size()) begin
        chk($sformatf("t3_beat%0d_value", k), 32'(got_q[k].v), 32'(10 * (k + 1)));
        chk($sformatf("t3_beat%0d_index", k), 32'(got_q[k].i), 32'(k % LANES));
        chk($sformatf("t3_beat%0d_last", k),  32'(got_q[k].l), 32'(k == 5));
        $display("stall beat %0d: value=%0d index=%0d", k, got_q[k].v, got_q[k].i);
      end
    end
    chk("t3_frames", 32'(frm_q.size()), 1);
    chk_frame("t3", 0, '{10'd60, 16'd5, 3'd0, 16'd6});

    // Test 4: tie across beats keeps the earliest winner.
    frm_q.delete();
    send(1'b1, pk(300, 0, 0, 0, 0), 1'b0);
    send(1'b1, pk(0, 0, 900, 0, 0), 1'b0);
    send(1'b1, pk(900, 0, 0, 0, 0), 1'b1);
    idle();
    cycles(8);
    chk("t4_frames", 32'(frm_q.size()), 1);
    chk_frame("t4", 0, '{10'd900, 16'd1, 3'd2, 16'd3});
    $display("test4 frame: value=%0d beat=%0d count=%0d", frame_value, frame_beat, frame_count);

    // Test 5: reset mid-frame discards the partial frame.
    frm_q.delete();
    send(1'b1, pk(50, 60, 70, 80, 90), 1'b0);
    idle();
    cycles(5);
    send(1'b1, pk(10, 20, 30, 40, 50), 1'b0);
    idle();
    cycles(1);
    reset_n = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    @(negedge clock);
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_frame_value", 32'(frame_value), 0);
    chk("t5_frame_beat", 32'(frame_beat), 0);
    chk("t5_frame_lane", 32'(frame_lane), 0);
    chk("t5_frame_count", 32'(frame_count), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    @(posedge clock); #1;
    cycles(4);
    chk("t5_no_fdone", 32'(frm_q.size()), 0);
    send(1'b1, pk(5, 6, 7, 8, 9), 1'b1);
    idle();
    cycles(8);
    chk("t5_frames", 32'(frm_q.size()), 1);
    chk_frame("t5", 0, '{10'd9, 16'd0, 3'd4, 16'd1});

    // Test 6: two back-to-back frames, max then min.
    frm_q.delete();
    send(1'b1, pk(1, 2, 3, 4, 5), 1'b1);
    send(1'b0, pk(5, 4, 3, 2, 1), 1'b1);
    idle();
    cycles(8);
    chk("t6_frames", 32'(frm_q.size()), 2);
    chk_frame("t6a", 0, '{10'd5, 16'd0, 3'd4, 16'd1});
    chk_frame("t6b", 1, '{10'd1, 16'd0, 3'd4, 16'd1});
    $display("test6 frames seen: %0d", frm_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
